// File: rtl/f_le_server.sv
`default_nettype none
// ============================================================================
// f_le_server : shared 4-state "a <= b" IEEE-754 comparator, 2-port RR arbiter
// Revision    : 1.0
// ============================================================================
module f_le_server #(
  parameter int FLEN = 64,
  parameter int EXPW = 11,
  parameter int MANW = 52
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [1:0][FLEN-1:0] req_a,
  input  logic [1:0][FLEN-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic                 rsp_res,
  output logic                 rsp_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLASS = 2'd1,
    S_MAG   = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            rr_last_q, rr_last_d;
  logic [FLEN-1:0] a_q, a_d, b_q, b_d;
  logic            id_q, id_d;
  logic            sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic            nan_a_q, nan_a_d, nan_b_q, nan_b_d;
  logic            zero_a_q, zero_a_d, zero_b_q, zero_b_d;
  logic            exp_lt_q, exp_lt_d, exp_gt_q, exp_gt_d, exp_eq_q, exp_eq_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_id_q, rsp_id_d;
  logic            rsp_res_q, rsp_res_d;
  logic            rsp_err_q, rsp_err_d;

  logic            grant;
  logic [EXPW-1:0] exp_a, exp_b;
  logic [MANW-1:0] man_a, man_b;
  logic            mag_le, mag_ge, res_calc;

  assign exp_a = a_q[FLEN-2 -: EXPW];
  assign exp_b = b_q[FLEN-2 -: EXPW];
  assign man_a = a_q[MANW-1:0];
  assign man_b = b_q[MANW-1:0];

  // With both ports valid, the port not served last wins.
  always_comb begin
    grant = 1'b0;
    case (req_valid)
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~rr_last_q;
      default: grant = 1'b0;
    endcase
    req_ready = 2'b00;
    if (state_q == S_IDLE) begin
      req_ready[0] = req_valid[0] & ~grant;
      req_ready[1] = req_valid[1] &  grant;
    end
  end

  always_comb begin
    mag_le   = exp_lt_q | (exp_eq_q & (man_a <= man_b));
    mag_ge   = exp_gt_q | (exp_eq_q & (man_a >= man_b));
    res_calc = 1'b0;
    if (nan_a_q | nan_b_q)        res_calc = 1'b0;
    else if (zero_a_q & zero_b_q) res_calc = 1'b1;
    else if (sign_a_q != sign_b_q) res_calc = sign_a_q;
    else if (sign_a_q)            res_calc = mag_ge;
    else                          res_calc = mag_le;
  end

  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    nan_a_d     = nan_a_q;
    nan_b_d     = nan_b_q;
    zero_a_d    = zero_a_q;
    zero_b_d    = zero_b_q;
    exp_lt_d    = exp_lt_q;
    exp_gt_d    = exp_gt_q;
    exp_eq_d    = exp_eq_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_res_d   = rsp_res_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (|(req_valid & req_ready)) begin
          a_d     = req_a[grant];
          b_d     = req_b[grant];
          id_d    = grant;
          state_d = S_CLASS;
        end
      end
      S_CLASS: begin
        sign_a_d = a_q[FLEN-1];
        sign_b_d = b_q[FLEN-1];
        nan_a_d  = (&exp_a) & (|man_a);
        nan_b_d  = (&exp_b) & (|man_b);
        zero_a_d = ~(|exp_a) & ~(|man_a);
        zero_b_d = ~(|exp_b) & ~(|man_b);
        exp_lt_d = exp_a < exp_b;
        exp_gt_d = exp_a > exp_b;
        exp_eq_d = exp_a == exp_b;
        state_d  = S_MAG;
      end
      S_MAG: begin
        rsp_res_d   = res_calc;
        rsp_err_d   = nan_a_q | nan_b_q;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rr_last_d   = id_q;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_last_q   <= 1'b1;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= 1'b0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      nan_a_q     <= 1'b0;
      nan_b_q     <= 1'b0;
      zero_a_q    <= 1'b0;
      zero_b_q    <= 1'b0;
      exp_lt_q    <= 1'b0;
      exp_gt_q    <= 1'b0;
      exp_eq_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_res_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      nan_a_q     <= nan_a_d;
      nan_b_q     <= nan_b_d;
      zero_a_q    <= zero_a_d;
      zero_b_q    <= zero_b_d;
      exp_lt_q    <= exp_lt_d;
      exp_gt_q    <= exp_gt_d;
      exp_eq_q    <= exp_eq_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_res_q   <= rsp_res_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_res   = rsp_res_q;
  assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire
